// File: rtl/adder_arb_pkg.sv
// Shared defaults and helpers for the shared-adder round-robin arbiter.
package adder_arb_pkg;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned W_DEFAULT    = 8;

    function automatic int unsigned id_width(input int unsigned n);
        return $clog2(n);
    endfunction

    localparam int unsigned ID_W = id_width(NREQ_DEFAULT);

endpackage

// File: rtl/adder_share_arb_rr_pick.sv
// Combinational round-robin one-hot selector: first set req at or after ptr, wrapping.
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx
);

    logic w_found;

    // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && i_req[j] && (IW'(j) >= i_ptr)) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && i_req[j]) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one registered adder among NREQ requesters,
// with a single-entry response slot that stalls under back-pressure.
module adder_share_arb
    import adder_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned W    = W_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*W-1:0]     i_a,
    input  logic [NREQ*W-1:0]     i_b,
    output logic [NREQ-1:0]       o_gnt,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [$clog2(NREQ)-1:0] o_rsp_id,
    output logic [W:0]            o_rsp_sum,
    output logic                  o_busy
);

    localparam int unsigned IW = id_width(NREQ);

    logic            r_rsp_valid;
    logic [IW-1:0]   r_rsp_id;
    logic [W:0]      r_rsp_sum;
    logic [IW-1:0]   r_ptr;

    logic            w_slot_free;
    logic            w_issue;
    logic [NREQ-1:0] w_pick_gnt;
    logic [IW-1:0]   w_pick_idx;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx)
    );

    assign w_slot_free = !r_rsp_valid || i_rsp_ready;
    assign w_issue     = w_slot_free && (|i_req) && !i_rst;
    assign o_gnt       = w_issue ? w_pick_gnt : '0;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_gnt[i]) begin
                w_a = i_a[i*W +: W];
                w_b = i_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_ptr       <= '0;
        end else if (w_slot_free) begin
            if (w_issue) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= w_pick_idx;
                r_rsp_sum   <= {1'b0, w_a} + {1'b0, w_b};
                r_ptr       <= (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
            end else begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_sum   = r_rsp_sum;
    assign o_busy      = r_rsp_valid && !i_rsp_ready;

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and sequencer that shares one registered adder (sum = a + b, one-cycle latency) among NREQ requesters. Each requester presents operands with a request; the block grants one requester per cycle, launches its operands into the adder stage, and returns the sum tagged with the requester index. The block sits between the stimulus agents and the shared adder datapath. It applies back-pressure from a single downstream response consumer.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, operand width; sum width is W+1
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; held high until granted
- a  in  NREQ×W  per-requester operand A (packed, requester i at [i*W +: W])
- b  in  NREQ×W  per-requester operand B (same packing)
- gnt  out  NREQ  one-hot grant; combinational in the cycle the operands are captured
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result when rsp_valid & rsp_ready
- rsp_id  out  $clog2(NREQ)  index of requester owning rsp_sum
- rsp_sum  out  W+1  a + b, zero-extended, no overflow loss
- busy  out  1  rsp_valid held and not accepted (stall indicator)

## Operation
- Slot free when !rsp_valid | rsp_ready. Grant is issued only when the slot is free and |req.
- Round-robin order: search starts at pointer ptr and wraps modulo NREQ. The first requester with req set wins. At most one gnt bit is set; gnt = 0 when the slot is not free or there is no request.
- On a clock edge with a grant to requester i: rsp_sum <= a[i] + b[i] (W+1 bits), rsp_id <= i, rsp_valid <= 1, ptr <= (i+1) mod NREQ.
- On a clock edge with the slot free and no grant: rsp_valid <= 0. rsp_sum and rsp_id hold their last values.
- On a clock edge with the slot not free (rsp_valid & !rsp_ready): all output registers and ptr hold; busy = 1.
- A requester whose req drops before it is granted is skipped without error. Operands are sampled only on the granted edge.
- States, derived from rsp_valid and rsp_ready:
  - IDLE: rsp_valid = 0.
  - RESP: rsp_valid = 1 and accepted this cycle. This is a back-to-back issue point.
  - STALL: rsp_valid = 1 and not accepted.
- Transitions:
  - IDLE→RESP on grant.
  - RESP→RESP on grant; RESP→IDLE with no request.
  - RESP→STALL when !rsp_ready.
  - STALL→RESP/IDLE once rsp_ready rises. A new grant may launch in the same cycle the held result is accepted.

## Timing
- Reset (sync, rst high at an edge): rsp_valid=0, rsp_sum=0, rsp_id=0, ptr=0, busy=0. gnt=0 while rst is high.
- Latency: the grant in cycle T produces the result visible after edge T, so rsp_valid is high in cycle T+1.
- Throughput: one result per cycle while rsp_ready stays high.
- rst asserted mid-stall drops the pending result. No requester is re-granted until rst deasserts.
- Fairness: a continuously requesting requester is granted within NREQ grant opportunities.
- rsp_sum width rule: max operands (2^W−1) + (2^W−1) = 2^(W+1)−2, which fits in W+1 bits.

## Structure
- Shared package adder_arb_pkg: default W, default NREQ, and the localparam ID_W = $clog2(NREQ).
- Sub-module rr_pick: combinational round-robin one-hot selector (inputs req and ptr; outputs gnt and the encoded index).
- The adder stage is a registered a+b in the top. It is not a separate module.

## Test plan
- Reset then single request: req=0001, a0=3, b0=4 → gnt=0001 in that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=7.
- All four requesting continuously, rsp_ready=1, ptr=0 → grant order 0,1,2,3,0 on consecutive cycles; rsp_id follows one cycle later.
- Overflow at W=8: a=255, b=255 → rsp_sum=510 (9'h1FE).
- Back-pressure: results pending with rsp_ready=0 for 3 cycles → gnt=0, busy=1, rsp_sum/rsp_id stable. When rsp_ready rises, the next grant occurs the same cycle.
- Wrap and skip: ptr=3, req=0101 → requester 0 granted, then requester 2. A requester dropping req before grant is never reported.
- Sync reset during STALL (rst held 1 cycle) → next cycle rsp_valid=0, ptr=0. A requester held through reset is granted in the first cycle after rst falls.
